// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the ALU family
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_MUL = 4'b1001,
        OP_DIV = 4'b1010,
        OP_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // A zero divisor is resolved immediately, so only real MUL/DIV work iterates.
    function automatic logic is_iter_op(input logic [3:0] op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result_next
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic             mode_div;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] opa_next;
    logic [WIDTH-1:0] opb_next;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH:0]   div_diff;
    logic             div_neg;

    // acc is the product accumulator for MUL and the partial remainder for DIV;
    // opa holds the shifting multiplicand or the dividend turning into the quotient.
    always_comb begin
        acc_next    = acc;
        opa_next    = opa;
        opb_next    = opb;
        div_shifted = {acc, opa[WIDTH-1]};
        div_diff    = div_shifted - {1'b0, opb};
        div_neg     = (div_shifted < {1'b0, opb});
        if (mode_div) begin
            acc_next = div_neg ? div_shifted[WIDTH-1:0] : div_diff[WIDTH-1:0];
            opa_next = {opa[WIDTH-2:0], ~div_neg};
        end else begin
            acc_next = acc + (opb[0] ? opa : '0);
            opa_next = {opa[WIDTH-2:0], 1'b0};
            opb_next = {1'b0, opb[WIDTH-1:1]};
        end
    end

    assign result_next = mode_div ? opa_next : acc_next;
    assign last        = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mode_div <= 1'b0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
        end else if (load) begin
            cnt      <= '0;
            mode_div <= is_div;
            acc      <= '0;
            opa      <= a;
            opb      <= b;
        end else if (step) begin
            cnt <= cnt + CW'(1);
            acc <= acc_next;
            opa <= opa_next;
            opb <= opb_next;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - ALU with single-cycle logic/arith ops and iterative MUL/DIV
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    alu_state_e       state;
    alu_state_e       state_next;
    logic             accept;
    logic             iter_start;
    logic             iter_last;
    logic             b_zero;
    logic [WIDTH-1:0] quick_res;
    logic [WIDTH-1:0] iter_res;

    assign b_zero     = (b_in == '0);
    assign accept     = start && (state != ST_ITER);
    assign iter_start = accept && is_iter_op(ALUop, b_zero);

    always_comb begin
        quick_res = '0;
        case (ALUop)
            OP_AND:  quick_res = a_in & b_in;
            OP_OR:   quick_res = a_in | b_in;
            OP_NOR:  quick_res = ~(a_in | b_in);
            OP_ADD:  quick_res = a_in + b_in;
            OP_SUB:  quick_res = a_in - b_in;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            OP_DIV:  quick_res = '1;  // only reached here with a zero divisor
            default: quick_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (accept) begin
                    state_next = iter_start ? ST_ITER : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ITER: begin
                busy = 1'b1;
                if (iter_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Visible outputs change only when a result completes; the error flag is
    // additionally dropped as soon as a new iterative operation is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result      <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
        end else if (accept && !iter_start) begin
            result      <= quick_res;
            zero        <= (quick_res == '0);
            div_by_zero <= (ALUop == OP_DIV);
        end else if (iter_start) begin
            div_by_zero <= 1'b0;
        end else if (busy && iter_last) begin
            result <= iter_res;
            zero   <= (iter_res == '0);
        end
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst        (rst),
        .load       (iter_start),
        .is_div     (ALUop == OP_DIV),
        .step       (busy),
        .a          (a_in),
        .b          (b_in),
        .last       (iter_last),
        .result_next(iter_res)
    );

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu at WIDTH=32
module tb_multicycle_alu;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_MUL = 4'b1001;
    localparam logic [3:0] C_DIV = 4'b1010;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_ILL = 4'b0011;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  ALUop;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ALUop      (ALUop),
        .a_in       (a_in),
        .b_in       (b_in),
        .result     (result),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dbz = 1'b0;
        e.lat = 1;
        case (op)
            C_AND: e.res = a & b;
            C_OR:  e.res = a | b;
            C_NOR: e.res = ~(a | b);
            C_ADD: e.res = a + b;
            C_SUB: e.res = a - b;
            C_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_MUL: begin
                e.res = a * b;
                e.lat = 33;
            end
            C_DIV: begin
                if (b == 32'd0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else begin
                    e.res = a / b;
                    e.lat = 33;
                end
            end
            default: e.res = 32'd0;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int gap);
        exp_t e;
        repeat (gap) @(negedge clk);
        e     = model(op, a, b);
        start = 1'b1;
        ALUop = op;
        a_in  = a;
        b_in  = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        ALUop = 4'($urandom);
        a_in  = $urandom;
        b_in  = $urandom;
        check("dbz_after_accept", div_by_zero, (e.dbz && e.lat == 1) ? 1 : 0);
    endtask

    task automatic wait_check(input string tag, input int inject);
        exp_t e;
        int   lat   = 1;
        int   bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (inject != 0 && lat == inject) begin
                start = 1'b1;
                ALUop = C_ADD;
                a_in  = 32'd1;
                b_in  = 32'd2;
            end else if (inject != 0 && lat == inject + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_zero"}, zero, (e.res == 32'd0) ? 1 : 0);
            check({tag, "_dbz"}, div_by_zero, e.dbz);
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_busy_cycles"}, bcnt, e.lat - 1);
        end
    endtask

    logic [3:0] op_tab [10] = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_MUL, C_DIV, C_NOR, C_ILL, 4'b1111};

    initial begin
        exp_t dropped;
        logic seen_done;
        logic [31:0] ra;
        logic [31:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        ALUop = 4'd0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        issue(C_ADD, 32'd10, 32'd5, 0);          wait_check("add", 0);
        issue(C_SUB, 32'd5, 32'd5, 2);           wait_check("sub_zero", 0);
        issue(C_MUL, 32'd10, 32'd6, 2);          wait_check("mul_small", 0);
        issue(C_MUL, 32'hFFFF_FFFF, 32'd2, 2);   wait_check("mul_wrap", 0);
        issue(C_DIV, 32'd10, 32'd5, 2);          wait_check("div", 0);
        issue(C_DIV, 32'd7, 32'd0, 2);           wait_check("div_zero", 0);
        issue(C_SLT, 32'hFFFF_FFFF, 32'd5, 2);   wait_check("slt_neg", 0);
        issue(C_SLT, 32'd10, 32'd5, 2);          wait_check("slt_pos", 0);
        issue(C_ILL, 32'd12, 32'd34, 2);         wait_check("illegal", 0);
        issue(C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 2); wait_check("and", 0);
        issue(C_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 2); wait_check("or", 0);
        issue(C_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 2); wait_check("nor", 0);
        issue(C_ADD, 32'hFFFF_FFFF, 32'd1, 2);   wait_check("add_wrap", 0);

        issue(C_MUL, 32'd1234, 32'd5678, 2);     wait_check("mul_ignore_start", 5);

        issue(C_DIV, 32'd9, 32'd0, 2);           wait_check("b2b_div0", 0);
        issue(C_MUL, 32'd10, 32'd6, 0);          wait_check("b2b_mul", 0);
        issue(C_DIV, 32'd100, 32'd7, 0);         wait_check("b2b_div", 0);
        issue(C_ADD, 32'd40, 32'd2, 0);          wait_check("b2b_add", 0);
        issue(C_SUB, 32'd3, 32'd9, 0);           wait_check("b2b_sub", 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            issue(op_tab[$urandom_range(0, 9)], ra, rb, $urandom_range(0, 2));
            wait_check("rand", 0);
        end

        issue(C_ADD, 32'd100, 32'd1, 2);         wait_check("pre_rst_add", 0);
        issue(C_DIV, 32'd1000, 32'd7, 2);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_div_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        dropped = sb.pop_front();
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("no_done_in_rst", seen_done, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(C_ADD, 32'd3, 32'd4, 0);           wait_check("post_rst_add", 0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("no_stray_done", seen_done, 0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled on the rising edge of clk.
REQ-005 The block SHALL have port ALUop, input, 4, operation select.
REQ-006 The block SHALL have ports a_in and b_in, input, WIDTH each, operands.
REQ-007 The block SHALL have port result, output, WIDTH, the registered result.
REQ-008 The block SHALL have port zero, output, 1, high when result is all zeros.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse marking result valid.
REQ-011 The block SHALL have port div_by_zero, output, 1, error flag for the last DIV.

Function
REQ-012 Opcodes SHALL be AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, MUL 1001, DIV 1010, NOR 1100; every other code is illegal.
REQ-013 A start SHALL be accepted only in state IDLE or DONE; a start while busy SHALL be ignored with no effect.
REQ-014 On acceptance, ALUop, a_in and b_in SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-015 The FSM SHALL have states IDLE, ITER and DONE: IDLE/DONE->ITER on an accepted MUL/DIV; IDLE/DONE->DONE on any other accepted op; ITER->DONE after WIDTH iterations; DONE->IDLE when start is low.
REQ-016 AND/OR/NOR/ADD/SUB/SLT/illegal ops SHALL set done one cycle after the accept edge; busy SHALL stay low.
REQ-017 ADD and SUB SHALL wrap modulo 2^WIDTH with no carry or overflow output.
REQ-018 SLT SHALL compare as two's-complement signed and return 1 or 0, zero-extended.
REQ-019 An illegal opcode SHALL produce result 0 (zero=1).
REQ-020 MUL SHALL be an unsigned shift-add over WIDTH iterations, one per cycle; result is the low WIDTH bits of the product.
REQ-021 DIV SHALL be an unsigned restoring divide over WIDTH iterations, one per cycle; result is the quotient.
REQ-022 For MUL/DIV, busy SHALL be high for exactly WIDTH cycles after the accept edge, and done SHALL pulse in the following cycle (latency WIDTH+1).
REQ-023 A DIV with b_in=0 SHALL skip ITER, go to DONE in one cycle, and return result all ones with div_by_zero=1.
REQ-024 div_by_zero SHALL clear on the next accepted start.
REQ-025 result, zero and div_by_zero SHALL update only in the cycle done rises and SHALL hold until the next done.
REQ-026 A start accepted in DONE SHALL begin the new operation back-to-back; done SHALL NOT pulse in the intervening cycle.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE immediately; result=0, zero=1, busy=0, done=0, div_by_zero=0.
REQ-028 Reset during ITER SHALL abandon the operation, produce no done, and leave no partial result visible.
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-030 Opcode constants and FSM state encodings SHALL live in a shared package (alu_pkg), also used by the single-cycle ALU.
REQ-031 The iterative datapath SHALL be one sub-module, alu_muldiv_iter (shift registers, accumulator, iteration counter); logic ops stay in the top level.

Verification (WIDTH=32)
REQ-032 ADD a=10,b=5 -> done one cycle after accept, result=15, zero=0; SUB 5-5 -> result=0, zero=1.
REQ-033 MUL a=10,b=6 -> busy high for 32 cycles, done on cycle 33, result=60; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-034 DIV a=10,b=5 -> result=2 at latency 33; DIV a=7,b=0 -> done after 1 cycle, result=0xFFFFFFFF, div_by_zero=1.
REQ-035 SLT a=0xFFFFFFFF (-1),b=5 -> result=1; SLT a=10,b=5 -> result=0; illegal op 0011 -> result=0.
REQ-036 During MUL, start with ADD on cycle 5 -> ignored, final result is the MUL product; back-to-back start in DONE -> second result correct.
REQ-037 rst asserted mid-DIV at cycle 10 -> outputs at reset values immediately, no done pulse; next ADD is accepted normally.
